// File: rtl/cl_lsu_ctrl_if.sv
// Data-memory request/response bus between the load/store control stage and memory.
// Request uses valid/yumi; the read response is a single rv strobe with data.
interface cl_lsu_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  v;
   logic                  w;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic [3:0]            mask;
   logic                  yumi;
   logic                  rv;
   logic [31:0]           rdata;

   modport master (
      output v, w, addr, wdata, mask,
      input  yumi, rv, rdata
   );

   modport slave (
      input  v, w, addr, wdata, mask,
      output yumi, rv, rdata
   );
endinterface

// File: rtl/cl_lsu_ctrl.sv
// Load/store control stage: one data-memory request at a time, byte alignment, writeback.
// Optional LSU_MISALIGN_TRAP_EN: misaligned word ops are consumed in IDLE and flagged.
module cl_lsu_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned RD_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   input  logic                  is_mem_op_i,
   input  logic                  is_load_op_i,
   input  logic                  is_store_op_i,
   input  logic                  is_byte_op_i,
   input  logic                  op_writes_rf_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           store_data_i,
   input  logic [RD_WIDTH-1:0]   rd_addr_i,
   output logic                  stall_o,
   cl_lsu_ctrl_if.master         dmem,
   output logic                  wb_v_o,
   output logic [RD_WIDTH-1:0]   wb_rd_o,
   output logic [31:0]           wb_data_o,
   output logic                  misalign_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;
   logic                  byte_q;
   logic                  store_q;
   logic                  wb_en_q;
   logic [RD_WIDTH-1:0]   rd_q;
   logic                  wb_v_q;
   logic [RD_WIDTH-1:0]   wb_rd_q;
   logic [31:0]           wb_data_q;

   logic        accept;
   logic        trap;
   logic        start;
   logic        req_v;
   logic        stall;
   logic        load_done;
   logic [1:0]  byte_off;
   logic [31:0] load_data;

   assign accept = (state_q == StIdle) & valid_i & is_mem_op_i;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_q;

   assign trap = accept & ~is_byte_op_i & (addr_i[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= trap;
   end

   assign misalign_o = misalign_q;
`else
   assign trap       = 1'b0;
   assign misalign_o = 1'b0;
`endif

   assign start = accept & ~trap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start)     state_d = StReq;
         StReq:   if (dmem.yumi) state_d = store_q ? StIdle : StWait;
         StWait:  if (dmem.rv)   state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   // Request is purely state-decoded so reset withdraws it without waiting for a clock.
   always_comb begin
      req_v     = 1'b0;
      stall     = start;
      load_done = 1'b0;
      unique case (state_q)
         StIdle: ;
         StReq: begin
            req_v = 1'b1;
            stall = ~(dmem.yumi & store_q);
         end
         StWait: begin
            stall     = ~dmem.rv;
            load_done = dmem.rv;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         data_q    <= '0;
         byte_q    <= 1'b0;
         store_q   <= 1'b0;
         wb_en_q   <= 1'b0;
         rd_q      <= '0;
         wb_v_q    <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         if (start) begin
            addr_q  <= addr_i;
            data_q  <= store_data_i;
            byte_q  <= is_byte_op_i;
            store_q <= is_store_op_i;
            wb_en_q <= is_load_op_i & op_writes_rf_i & (rd_addr_i != '0);
            rd_q    <= rd_addr_i;
         end
         wb_v_q <= load_done & wb_en_q;
         if (load_done) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= load_data;
         end
      end
   end

   assign byte_off  = addr_q[1:0];
   assign load_data = byte_q ? {24'h0, dmem.rdata[{byte_off, 3'b000} +: 8]} : dmem.rdata;

   assign dmem.v     = req_v;
   assign dmem.w     = store_q;
   assign dmem.addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign dmem.wdata = byte_q ? {4{data_q[7:0]}} : data_q;
   assign dmem.mask  = byte_q ? (4'b0001 << byte_off) : 4'hF;

   assign stall_o   = stall;
   assign wb_v_o    = wb_v_q;
   assign wb_rd_o   = wb_rd_q;
   assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_cl_lsu_ctrl.sv
// Scoreboard bench for cl_lsu_ctrl: directed ops push expected requests/writebacks,
// a monitor pops and compares whenever the DUT presents them.
module tb_cl_lsu_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        valid, is_mem, is_load, is_store, is_byte, writes_rf;
   logic [31:0] addr, sdata;
   logic [4:0]  rd;
   logic        stall, wb_v, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   cl_lsu_ctrl_if #(.ADDR_WIDTH(32)) mif ();

   cl_lsu_ctrl #(.ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_i        (valid),
      .is_mem_op_i    (is_mem),
      .is_load_op_i   (is_load),
      .is_store_op_i  (is_store),
      .is_byte_op_i   (is_byte),
      .op_writes_rf_i (writes_rf),
      .addr_i         (addr),
      .store_data_i   (sdata),
      .rd_addr_i      (rd),
      .stall_o        (stall),
      .dmem           (mif.master),
      .wb_v_o         (wb_v),
      .wb_rd_o        (wb_rd),
      .wb_data_o      (wb_data),
      .misalign_o     (misalign)
   );

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } req_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   req_t req_q[$];
   wb_t  wb_q[$];
   int   mis_pend = 0;
   int   checks   = 0;
   int   errors   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   req_t mon_r;
   wb_t  mon_w;
   always begin
      @(negedge clk);
      #2;
      if (!reset) begin
         if (mif.v && mif.yumi) begin
            check("req_expected", req_q.size() > 0, 1'b1);
            if (req_q.size() > 0) begin
               mon_r = req_q.pop_front();
               check("req_w", mif.w, mon_r.w);
               check("req_addr", mif.addr, mon_r.addr);
               if (mon_r.w) begin
                  check("req_wdata", mif.wdata, mon_r.wdata);
                  check("req_mask", mif.mask, mon_r.mask);
               end
            end
         end
         if (wb_v) begin
            check("wb_expected", wb_q.size() > 0, 1'b1);
            if (wb_q.size() > 0) begin
               mon_w = wb_q.pop_front();
               check("wb_rd", wb_rd, mon_w.rd);
               check("wb_data", wb_data, mon_w.data);
            end
         end
         if (misalign) begin
            check("misalign_expected", mis_pend > 0, 1'b1);
            if (mis_pend > 0) mis_pend--;
         end
      end
   end

   task automatic clear_inputs();
      valid = 0; is_mem = 0; is_load = 0; is_store = 0; is_byte = 0; writes_rf = 0;
      addr = 0; sdata = 0; rd = 0;
   endtask

   // yd: REQ cycles before yumi; rvd: WAIT cycles before rv; early: rv pulsed with yumi.
   task automatic run_op(input string name, input bit st, input bit by, input bit wrf,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input int yd, input int rvd, input bit early, input logic [31:0] rdata,
                         input bit exp_req, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
                         input bit exp_wb, input logic [31:0] exp_wbd, input int exp_stall,
                         input bit exp_mis);
      req_t        er;
      wb_t         ew;
      int          stall_cnt, vcnt, wcnt, cyc;
      bit          waiting, seen, stable_ok, done;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_mask;
      logic        s_w;
      if (exp_req) begin
         er.w = st; er.addr = exp_addr; er.wdata = exp_wdata; er.mask = exp_mask;
         req_q.push_back(er);
      end
      if (exp_wb) begin
         ew.rd = r; ew.data = exp_wbd;
         wb_q.push_back(ew);
      end
      if (exp_mis) mis_pend++;
      @(posedge clk); #1;
      valid = 1; is_mem = 1; is_load = !st; is_store = st; is_byte = by;
      writes_rf = wrf; addr = a; sdata = d; rd = r;
      stall_cnt = 0; vcnt = 0; wcnt = 0; cyc = 0;
      waiting = 0; seen = 0; stable_ok = 1; done = 0;
      s_addr = 0; s_wdata = 0; s_mask = 0; s_w = 0;
      while (!done && cyc < 60) begin
         cyc++;
         @(negedge clk);
         if (mif.v) begin
            if (!seen) begin
               seen = 1; s_addr = mif.addr; s_wdata = mif.wdata; s_mask = mif.mask; s_w = mif.w;
            end else if (mif.addr !== s_addr || mif.wdata !== s_wdata ||
                         mif.mask !== s_mask || mif.w !== s_w) begin
               stable_ok = 0;
            end
            if (vcnt == yd) begin
               mif.yumi = 1;
               if (early) begin mif.rv = 1; mif.rdata = 32'hFFFF_FFFF; end
            end
            vcnt++;
         end else if (waiting) begin
            if (wcnt == rvd) begin mif.rv = 1; mif.rdata = rdata; end
            wcnt++;
         end
         #1;
         if (stall) stall_cnt++;
         else done = 1;
         @(posedge clk);
         if (mif.yumi && !st) waiting = 1;
         #1;
         mif.yumi = 0; mif.rv = 0;
      end
      clear_inputs();
      check({name, "_completed"}, done, 1'b1);
      check({name, "_stall_cycles"}, stall_cnt, exp_stall);
      check({name, "_req_seen"}, seen, exp_req);
      if (exp_req) check({name, "_req_stable"}, stable_ok, 1'b1);
      repeat (2) @(posedge clk);
   endtask

   int wcyc;
   initial begin
      reset = 1;
      clear_inputs();
      mif.yumi = 0; mif.rv = 0; mif.rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_dmem_v", mif.v, 1'b0);
      check("rst_wb_v", wb_v, 1'b0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_misalign", misalign, 1'b0);
      reset = 0;

      run_op("lw_104", 0, 0, 1, 32'h104, 0, 5'd3, 1, 0, 0, 32'hDEADBEEF,
             1, 32'h104, 0, 0, 1, 32'hDEADBEEF, 3, 0);
      run_op("lbu_107", 0, 1, 1, 32'h107, 0, 5'd5, 0, 1, 0, 32'hAABBCCDD,
             1, 32'h104, 0, 0, 1, 32'h0000_00AA, 3, 0);
      run_op("sb_202", 1, 1, 0, 32'h202, 32'h12345678, 5'd0, 0, 0, 0, 0,
             1, 32'h200, 32'h78787878, 4'b0100, 0, 0, 1, 0);
      run_op("sw_300_slow", 1, 0, 0, 32'h300, 32'hCAFEF00D, 5'd0, 5, 0, 0, 0,
             1, 32'h300, 32'hCAFEF00D, 4'hF, 0, 0, 6, 0);
      run_op("lw_rd0", 0, 0, 1, 32'h10, 0, 5'd0, 0, 0, 0, 32'h1234,
             1, 32'h10, 0, 0, 0, 0, 2, 0);
      run_op("lbu_early_rv", 0, 1, 1, 32'h1, 0, 5'd7, 0, 2, 1, 32'h11223344,
             1, 32'h0, 0, 0, 1, 32'h0000_0033, 4, 0);
      run_op("lw_no_rf", 0, 0, 0, 32'h20, 0, 5'd9, 0, 0, 0, 32'h5555,
             1, 32'h20, 0, 0, 0, 0, 2, 0);
      run_op("sb_003", 1, 1, 0, 32'h3, 32'hAB, 5'd0, 1, 0, 0, 0,
             1, 32'h0, 32'hABABABAB, 4'b1000, 0, 0, 2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      run_op("lw_101_trap", 0, 0, 1, 32'h101, 0, 5'd4, 0, 0, 0, 32'h55,
             0, 0, 0, 0, 0, 0, 0, 1);
`else
      run_op("lw_101_trunc", 0, 0, 1, 32'h101, 0, 5'd4, 0, 0, 0, 32'h55,
             1, 32'h100, 0, 0, 1, 32'h55, 2, 0);
`endif

      // Non-memory instruction: no stall, no request.
      @(posedge clk); #1;
      valid = 1; is_mem = 0;
      @(negedge clk); #1;
      check("nonmem_stall", stall, 1'b0);
      @(negedge clk); #1;
      check("nonmem_dmem_v", mif.v, 1'b0);
      @(posedge clk); #1;
      clear_inputs();

      // Stray response while idle must not produce a writeback.
      @(negedge clk);
      mif.rv = 1; mif.rdata = 32'h77;
      @(posedge clk); #1;
      mif.rv = 0;
      repeat (2) @(posedge clk);

      // Reset while waiting for a load response; the late response is dropped.
      begin
         req_t er;
         er.w = 0; er.addr = 32'h400; er.wdata = 0; er.mask = 0;
         req_q.push_back(er);
      end
      @(posedge clk); #1;
      valid = 1; is_mem = 1; is_load = 1; writes_rf = 1; addr = 32'h400; rd = 5'd6;
      wcyc = 0;
      @(negedge clk);
      while (!mif.v && wcyc < 20) begin
         wcyc++;
         @(negedge clk);
      end
      check("rstwait_req_seen", mif.v, 1'b1);
      mif.yumi = 1;
      @(posedge clk); #1;
      mif.yumi = 0;
      clear_inputs();
      @(negedge clk);
      check("rstwait_stall_in_wait", stall, 1'b1);
      #3;
      reset = 1;
      #1;
      check("rstwait_stall_async", stall, 1'b0);
      check("rstwait_dmem_v_async", mif.v, 1'b0);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      mif.rv = 1; mif.rdata = 32'h99;
      @(posedge clk); #1;
      mif.rv = 0;
      @(negedge clk); #1;
      check("rstwait_no_wb", wb_v, 1'b0);
      check("rstwait_stall_idle", stall, 1'b0);
      check("rstwait_wb_data_cleared", wb_data, 32'h0);
      repeat (2) @(posedge clk);

      check("req_queue_drained", req_q.size(), 0);
      check("wb_queue_drained", wb_q.size(), 0);
      check("misalign_drained", mis_pend, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
